// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem requests, response FIFO, valid/ready to decode.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

    state_t          r_state, w_state_next;
    logic [XLEN-1:0] r_pc, r_req_pc;
    logic            r_inflight;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [31:0]     r_fifo_instr [DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [31:0]     r_last_instr;
    logic [XLEN-1:0] r_last_pc;

    logic            w_head_valid, w_read, w_write, w_room, w_issue;
    logic [CW:0]     w_used, w_limit;

    assign w_head_valid = (r_count != '0);
    assign w_read       = w_head_valid & ~redirect_valid & instr_ready;
    assign w_write      = r_inflight & (r_state != SQUASH) & ~redirect_valid;
    // A slot freed by this cycle's read counts as credit, which sustains one fetch per cycle.
    assign w_used       = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_limit      = (CW+1)'(DEPTH) + (CW+1)'(w_read);
    assign w_room       = (w_used < w_limit);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            BOOT:        w_state_next = RUN;
            RUN, SQUASH: begin
                w_issue      = w_room;
                w_state_next = RUN;
            end
            default:     w_state_next = BOOT;
        endcase
        if (redirect_valid) begin
            w_issue      = 1'b0;
            w_state_next = r_inflight ? SQUASH : RUN;
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = w_head_valid & ~redirect_valid;
    assign instr       = w_head_valid ? r_fifo_instr[r_rd_ptr] : r_last_instr;
    assign instr_pc    = w_head_valid ? r_fifo_pc[r_rd_ptr]    : r_last_pc;
    assign opcode      = instr[6:0];

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_req_pc     <= '0;
            r_inflight   <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if (w_head_valid) begin
                r_last_instr <= instr;
                r_last_pc    <= instr_pc;
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc     <= redirect_pc & ~XLEN'(3);
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_read) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_write) - CW'(w_read);
            end
        end
    end

    // NOTE: FIFO storage has no reset; r_count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_squashed;
    logic        w_drop;

    assign w_drop = r_inflight & (r_state == SQUASH) & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched  <= '0;
            r_perf_squashed <= '0;
        end else begin
            if (w_read) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                r_perf_squashed <= r_perf_squashed + 32'(r_count) + 32'(r_inflight);
            end else if (w_drop) begin
                r_perf_squashed <= r_perf_squashed + 32'd1;
            end
        end
    end

    assign perf_fetched  = r_perf_fetched;
    assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem model, request/transfer scoreboard, redirect vector table.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [6:0]  w_opcode;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_squashed, w_perf_fetched, w_perf_squashed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .opcode(opcode),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
        .instr_pc(w_instr_pc), .opcode(w_opcode),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_squashed(w_perf_squashed)
`endif
    );

    typedef struct {
        logic [31:0] rpc;
        int          stall;
        logic [31:0] exp_pc;
    } redir_vec_t;

    int          n_checks, n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] xfer_log[$];
    logic [31:0] exp_addr;
    logic        pend_req;
    logic [31:0] pend_addr;
    int          cyc, first_valid_cyc, n_xfers, n_reqs, w_seen;
    logic        have_prev, prev_valid, prev_ready, prev_rv;
    logic [31:0] prev_instr, prev_pc;
    logic [31:0] wrap_exp [3];
    redir_vec_t  vecs [4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h4020_8133;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: expected event did not occur within budget", name);
    endtask

    // One clock: deliver last cycle's read data, drive inputs, then sample and score.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] pc, w;
        @(negedge clk);
        imem_rdata     = pend_req ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        cyc++;
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (have_prev && !prev_rv && !rv) begin
            if (!instr_valid || (prev_valid && !prev_ready)) begin
                check("hold_instr", instr, prev_instr);
                check("hold_pc", instr_pc, prev_pc);
            end
        end
        if (rv) begin
            check("redir_no_valid", {31'b0, instr_valid}, 32'd0);
            check("redir_no_req", {31'b0, imem_req}, 32'd0);
            exp_q.delete();
            exp_addr = rpc & ~32'd3;
        end
        if (instr_valid && instr_ready) begin
            n_xfers++;
            if (exp_q.size() == 0) begin
                fail("xfer_unexpected");
            end else begin
                pc = exp_q.pop_front();
                w  = mem_word(pc);
                check("xfer_pc", instr_pc, pc);
                check("xfer_instr", instr, w);
                check("xfer_opcode", {25'b0, opcode}, {25'b0, w[6:0]});
                xfer_log.push_back(instr_pc);
            end
        end
        if (imem_req) begin
            n_reqs++;
            check("imem_addr", imem_addr, exp_addr);
            exp_q.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
        end
        check("outstanding_le_depth", (exp_q.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        pend_req  = imem_req;
        pend_addr = imem_addr;
        if (w_imem_req && w_seen < 3) begin
            check("wrap_addr", w_imem_addr, wrap_exp[w_seen]);
            w_seen++;
        end
        have_prev  = 1'b1;
        prev_valid = instr_valid;
        prev_ready = instr_ready;
        prev_rv    = rv;
        prev_instr = instr;
        prev_pc    = instr_pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_rdata     = pend_req ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        rst_n          = 1'b0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_opcode", {25'b0, opcode}, 32'd0);
        exp_q.delete();
        exp_addr        = 32'h0000_0000;
        pend_req        = 1'b0;
        have_prev       = 1'b0;
        first_valid_cyc = -1;
        cyc             = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_first_xfer(input string name, input logic [31:0] exp_pc);
        for (int k = 0; k < 10 && xfer_log.size() == 0; k++) step(1'b1, 1'b0, 32'd0);
        if (xfer_log.size() == 0) fail(name);
        else check(name, xfer_log[0], exp_pc);
    endtask

    initial begin
        logic [31:0] tgt;
        int          n_before;
        n_checks = 0; n_errors = 0; n_xfers = 0; n_reqs = 0; w_seen = 0;
        cyc = 0; first_valid_cyc = -1; have_prev = 1'b0; pend_req = 1'b0; pend_addr = '0;
        exp_addr = '0;
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rdata = '0;
        w_imem_rdata = 32'h0000_0013; w_instr_ready = 1'b1;
        w_redirect_valid = 1'b0; w_redirect_pc = '0;
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[0] = '{32'h0000_0103, 4, 32'h0000_0100};
        vecs[1] = '{32'h0000_2002, 0, 32'h0000_2000};
        vecs[2] = '{32'hFFFF_FFFF, 1, 32'hFFFF_FFFC};
        vecs[3] = '{32'h0000_0046, 0, 32'h0000_0044};

        // Startup latency and first two instructions.
        do_reset();
        xfer_log.delete();
        repeat (8) step(1'b1, 1'b0, 32'd0);
        check("first_valid_cycle", first_valid_cyc, 32'd3);
        if (xfer_log.size() < 2) fail("first_two_xfers");
        else begin
            check("first_xfer_pc", xfer_log[0], 32'h0);
            check("second_xfer_pc", xfer_log[1], 32'h4);
        end

        // Decode stall from release: bounded requests, head held, then in-order drain at full rate.
        do_reset();
        xfer_log.delete();
        n_reqs = 0;
        repeat (12) step(1'b0, 1'b0, 32'd0);
        check("stall_reqs_le_depth", (n_reqs <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        check("stall_head_valid", {31'b0, instr_valid}, 32'd1);
        check("stall_head_pc", instr_pc, 32'h0);
        check("stall_no_xfer", xfer_log.size(), 32'd0);
        n_xfers = 0;
        repeat (20) step(1'b1, 1'b0, 32'd0);
        check("throughput", n_xfers, 32'd20);
        if (xfer_log.size() < 3) fail("drain_order");
        else begin
            check("drain_pc0", xfer_log[0], 32'h0);
            check("drain_pc1", xfer_log[1], 32'h4);
            check("drain_pc2", xfer_log[2], 32'h8);
        end

        // Redirect table: various FIFO fill levels and target alignments.
        for (int i = 0; i < 4; i++) begin
            repeat (4) step(1'b1, 1'b0, 32'd0);
            repeat (vecs[i].stall) step(1'b0, 1'b0, 32'd0);
            xfer_log.delete();
            step(1'b1, 1'b1, vecs[i].rpc);
            step(1'b1, 1'b0, 32'd0);
            check("redir_first_req", {31'b0, imem_req}, 32'd1);
            check("redir_first_addr", imem_addr, vecs[i].exp_pc);
            wait_first_xfer("redir_first_instr_pc", vecs[i].exp_pc);
        end

        // Back-to-back redirects: the last one wins.
        xfer_log.delete();
        step(1'b1, 1'b1, 32'h0000_0500);
        step(1'b0, 1'b1, 32'h0000_0603);
        step(1'b1, 1'b0, 32'd0);
        check("b2b_first_addr", imem_addr, 32'h0000_0600);
        wait_first_xfer("b2b_first_instr_pc", 32'h0000_0600);

        // Redirect in a valid&ready cycle back to the head's own PC.
        repeat (4) step(1'b1, 1'b0, 32'd0);
        if (exp_q.size() == 0) fail("self_redirect_setup");
        else begin
            tgt      = exp_q[0];
            n_before = n_xfers;
            xfer_log.delete();
            step(1'b1, 1'b1, tgt);
            check("self_redirect_not_counted", n_xfers, n_before);
            wait_first_xfer("self_redirect_refetch", tgt);
        end

        // Random ready/redirect traffic, fully scored.
        for (int k = 0; k < 80; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 $urandom & 32'h0000_0FFF);
        end

        // Reset pulse with a request in flight.
        repeat (3) step(1'b1, 1'b0, 32'd0);
        check("midrst_inflight_setup", {31'b0, pend_req}, 32'd1);
        do_reset();
        xfer_log.delete();
        wait_first_xfer("midrst_first_pc", 32'h0000_0000);
        repeat (6) step(1'b1, 1'b0, 32'd0);

        check("wrap_seen", w_seen, 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
